// File: rtl/mini_bus_arbiter.sv
// Purpose: shares one cache-style bus port between two requesters, round-robin, one transaction in flight.
// Latency: accept at cycle 0, bus address at 1, bus data at 2, requester data at 3, next accept at 4 at the earliest.
// Backpressure: valid/ready on every channel; requests wait (ready low) while a transaction is outstanding.
module mini_bus_arbiter #(
    parameter int data_width = 32,
    parameter int addr_width = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_addr_valid,
    output logic                  m0_addr_ready,
    input  logic [addr_width-1:0] m0_addr,
    output logic                  m0_data_valid,
    input  logic                  m0_data_ready,
    output logic [data_width-1:0] m0_data,
    input  logic                  m1_addr_valid,
    output logic                  m1_addr_ready,
    input  logic [addr_width-1:0] m1_addr,
    output logic                  m1_data_valid,
    input  logic                  m1_data_ready,
    output logic [data_width-1:0] m1_data,
    output logic                  bus_addr_valid,
    input  logic                  bus_addr_ready,
    output logic [addr_width-1:0] bus_addr,
    input  logic                  bus_data_valid,
    output logic                  bus_data_ready,
    input  logic [data_width-1:0] bus_data,
    output logic                  grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    prio_q, prio_d;
    logic                    grant_q, grant_d;
    logic                    bus_addr_valid_q, bus_addr_valid_d;
    logic [addr_width-1:0]   bus_addr_q, bus_addr_d;
    // The per-requester read-data registers double as the read-data buffer:
    // only the granted side's register is ever loaded.
    logic                    m0_data_valid_q, m0_data_valid_d;
    logic                    m1_data_valid_q, m1_data_valid_d;
    logic [data_width-1:0]   m0_data_q, m0_data_d;
    logic [data_width-1:0]   m1_data_q, m1_data_d;

    logic                    any_vld;
    logic                    sel;
    logic [addr_width-1:0]   sel_addr;
    logic                    rsp_rdy;

    // Round-robin pick: the priority holder wins if it asks, otherwise whoever asks.
    always_comb begin
        any_vld  = m0_addr_valid | m1_addr_valid;
        if (prio_q) begin
            sel = m1_addr_valid ? 1'b1 : 1'b0;
        end else begin
            sel = m0_addr_valid ? 1'b0 : 1'b1;
        end
        sel_addr = sel ? m1_addr : m0_addr;
        rsp_rdy  = grant_q ? m1_data_ready : m0_data_ready;
    end

    // Next-state and handshake outputs; readies are held low while reset is high.
    always_comb begin
        state_d          = state_q;
        prio_d           = prio_q;
        grant_d          = grant_q;
        bus_addr_valid_d = bus_addr_valid_q;
        bus_addr_d       = bus_addr_q;
        m0_data_valid_d  = m0_data_valid_q;
        m1_data_valid_d  = m1_data_valid_q;
        m0_data_d        = m0_data_q;
        m1_data_d        = m1_data_q;
        m0_addr_ready    = 1'b0;
        m1_addr_ready    = 1'b0;
        bus_data_ready   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_vld && !reset) begin
                    m0_addr_ready    = ~sel;
                    m1_addr_ready    = sel;
                    bus_addr_valid_d = 1'b1;
                    bus_addr_d       = sel_addr;
                    grant_d          = sel;
                    state_d          = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus_addr_ready) begin
                    bus_addr_valid_d = 1'b0;
                    state_d          = S_DATA;
                end
            end
            S_DATA: begin
                bus_data_ready = !reset;
                if (bus_data_valid && !reset) begin
                    if (grant_q) begin
                        m1_data_valid_d = 1'b1;
                        m1_data_d       = bus_data;
                    end else begin
                        m0_data_valid_d = 1'b1;
                        m0_data_d       = bus_data;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_rdy) begin
                    m0_data_valid_d = 1'b0;
                    m1_data_valid_d = 1'b0;
                    prio_d          = ~grant_q;
                    state_d         = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            prio_q           <= 1'b0;
            grant_q          <= 1'b0;
            bus_addr_valid_q <= 1'b0;
            bus_addr_q       <= '0;
            m0_data_valid_q  <= 1'b0;
            m1_data_valid_q  <= 1'b0;
            m0_data_q        <= '0;
            m1_data_q        <= '0;
        end else begin
            state_q          <= state_d;
            prio_q           <= prio_d;
            grant_q          <= grant_d;
            bus_addr_valid_q <= bus_addr_valid_d;
            bus_addr_q       <= bus_addr_d;
            m0_data_valid_q  <= m0_data_valid_d;
            m1_data_valid_q  <= m1_data_valid_d;
            m0_data_q        <= m0_data_d;
            m1_data_q        <= m1_data_d;
        end
    end

    assign m0_data_valid  = m0_data_valid_q;
    assign m1_data_valid  = m1_data_valid_q;
    assign m0_data        = m0_data_q;
    assign m1_data        = m1_data_q;
    assign bus_addr_valid = bus_addr_valid_q;
    assign bus_addr       = bus_addr_q;
    assign grant          = grant_q;
    assign busy           = (state_q != S_IDLE);

endmodule
